// File: rtl/channel_scanner.sv
// channel_scanner: sweeps a 3-bit channel select over the channels enabled
// in a latched mask. Each enabled channel is held for DWELL cycles. Scans run
// as a single pass or continuously. Every output is a flop.
// Optional feature: define CHANNEL_SCANNER_HOLD_EN to add the 'hold' input,
// which freezes the dwell counter and the channel select.
module channel_scanner #(
   parameter int DWELL = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       stop,
   input  logic [7:0] mask,
   input  logic       single,
`ifdef CHANNEL_SCANNER_HOLD_EN
   input  logic       hold,
`endif
   output logic [2:0] sel,
   output logic       sel_valid,
   output logic       busy,
   output logic       ch_done,
   output logic       pass_done
);

   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(DWELL - 1);

   typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [7:0]    mask_q, mask_d;
   logic          single_q, single_d;
   logic [2:0]    sel_q, sel_d;
   logic          sel_valid_q, sel_valid_d;
   logic          busy_q, busy_d;
   logic          ch_done_q, ch_done_d;
   logic          pass_done_q, pass_done_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          held;

   // Index of the lowest set bit (0 when the mask is empty).
   function automatic logic [2:0] lo_set(input logic [7:0] m);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 7; i >= 0; i--)
         if (m[i]) r = 3'(i);
      return r;
   endfunction

   // Index of the highest set bit: this channel ends a pass.
   function automatic logic [2:0] hi_set(input logic [7:0] m);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 0; i < 8; i++)
         if (m[i]) r = 3'(i);
      return r;
   endfunction

   // Next set bit strictly above cur, searching circularly. If cur is the only
   // set bit, the search lands on cur itself after a full wrap.
   function automatic logic [2:0] next_set(input logic [7:0] m, input logic [2:0] cur);
      logic [2:0] r;
      logic [2:0] idx;
      r = cur;
      for (int i = 8; i >= 1; i--) begin
         idx = cur + 3'(i);
         if (m[idx]) r = idx;
      end
      return r;
   endfunction

`ifdef CHANNEL_SCANNER_HOLD_EN
   assign held = hold;
`else
   assign held = 1'b0;
`endif

   // Next-state and next-output logic. The pulse outputs are computed from the
   // next counter value, so that a pulse lines up with the cycle in which the
   // counter reads 0.
   always_comb begin
      state_d     = state_q;
      mask_d      = mask_q;
      single_d    = single_q;
      sel_d       = sel_q;
      sel_valid_d = sel_valid_q;
      busy_d      = busy_q;
      cnt_d       = cnt_q;
      ch_done_d   = 1'b0;
      pass_done_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start && !stop && (mask != 8'd0)) begin
               state_d     = SCAN;
               mask_d      = mask;
               single_d    = single;
               sel_d       = lo_set(mask);
               sel_valid_d = 1'b1;
               busy_d      = 1'b1;
               cnt_d       = RELOAD;
            end
         end
         SCAN: begin
            if (stop) begin
               // Abort. Return to the reset values, with no pulse for the
               // aborted channel.
               state_d     = IDLE;
               mask_d      = 8'd0;
               single_d    = 1'b0;
               sel_d       = 3'd0;
               sel_valid_d = 1'b0;
               busy_d      = 1'b0;
               cnt_d       = '0;
            end else if (held) begin
               // The counter and sel keep their values. The pulses stay low.
            end else if (cnt_q == '0) begin
               if (single_q && (sel_q == hi_set(mask_q))) begin
                  state_d     = IDLE;
                  sel_d       = 3'd0;
                  sel_valid_d = 1'b0;
                  busy_d      = 1'b0;
                  cnt_d       = '0;
               end else begin
                  sel_d = next_set(mask_q, sel_q);
                  cnt_d = RELOAD;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if ((state_d == SCAN) && !stop && !held && (cnt_d == '0)) begin
         ch_done_d   = 1'b1;
         pass_done_d = (sel_d == hi_set(mask_d));
      end
   end

   // State and output registers, with an asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mask_q      <= 8'd0;
         single_q    <= 1'b0;
         sel_q       <= 3'd0;
         sel_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         ch_done_q   <= 1'b0;
         pass_done_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         single_q    <= single_d;
         sel_q       <= sel_d;
         sel_valid_q <= sel_valid_d;
         busy_q      <= busy_d;
         ch_done_q   <= ch_done_d;
         pass_done_q <= pass_done_d;
         cnt_q       <= cnt_d;
      end
   end

   assign sel       = sel_q;
   assign sel_valid = sel_valid_q;
   assign busy      = busy_q;
   assign ch_done   = ch_done_q;
   assign pass_done = pass_done_q;

endmodule

// File: tb/tb_channel_scanner.sv
// Directed bench for channel_scanner with DWELL=4. A table of per-cycle
// stimulus and expected outputs is followed by hand-written sequences for
// long passes, continuous wrap, asynchronous reset and, when enabled, hold.
module tb_channel_scanner;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic [7:0] mask = 8'd0;
   logic       single = 1'b0;
   logic       hold = 1'b0;
   logic [2:0] sel;
   logic       sel_valid, busy, ch_done, pass_done;

   int tests = 0;
   int fails = 0;

   channel_scanner #(.DWELL(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
      .mask(mask), .single(single),
`ifdef CHANNEL_SCANNER_HOLD_EN
      .hold(hold),
`endif
      .sel(sel), .sel_valid(sel_valid), .busy(busy),
      .ch_done(ch_done), .pass_done(pass_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       start, stop;
      logic [7:0] mask;
      logic       single;
      logic [2:0] sel;
      logic       v, b, cd, pd;
   } vec_t;

   vec_t tbl[29];

   function automatic vec_t mk(input logic st, input logic sp, input logic [7:0] m,
                               input logic sg, input logic [2:0] s, input logic v,
                               input logic b, input logic cd, input logic pd);
      vec_t r;
      r.start = st; r.stop = sp; r.mask = m; r.single = sg;
      r.sel = s; r.v = v; r.b = b; r.cd = cd; r.pd = pd;
      return r;
   endfunction

   task automatic check(input string name, input logic [2:0] es, input logic ev,
                        input logic eb, input logic ecd, input logic epd);
      logic [6:0] act, exp;
      act = {sel, sel_valid, busy, ch_done, pass_done};
      exp = {es, ev, eb, ecd, epd};
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got sel=%0d v=%b b=%b cd=%b pd=%b, want sel=%0d v=%b b=%b cd=%b pd=%b",
                  name, act[6:4], act[3], act[2], act[1], act[0],
                  es, ev, eb, ecd, epd);
      end
   endtask

   // Apply inputs for one cycle, then sample 1 time unit after the edge.
   task automatic step(input logic st, input logic sp, input logic [7:0] m,
                       input logic sg, input logic h);
      start = st; stop = sp; mask = m; single = sg; hold = h;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int seq[3];
      int k;
      seq[0] = 2; seq[1] = 5; seq[2] = 7;

      tbl[0]  = mk(1,0,8'h00,0, 0,0,0,0,0); // start with an empty mask is ignored
      tbl[1]  = mk(1,1,8'hFF,1, 0,0,0,0,0); // start and stop together: stop wins
      tbl[2]  = mk(1,0,8'hA4,0, 2,1,1,0,0);
      tbl[3]  = mk(0,0,8'h00,1, 2,1,1,0,0); // mask and single changes ignored
      tbl[4]  = mk(0,0,8'h00,1, 2,1,1,0,0);
      tbl[5]  = mk(0,0,8'h00,1, 2,1,1,1,0);
      tbl[6]  = mk(1,0,8'hFF,1, 5,1,1,0,0); // start while busy is ignored
      tbl[7]  = mk(0,0,8'hFF,0, 5,1,1,0,0);
      tbl[8]  = mk(0,0,8'hFF,0, 5,1,1,0,0);
      tbl[9]  = mk(0,1,8'hFF,0, 0,0,0,0,0); // stop just before the count reaches 0
      tbl[10] = mk(1,0,8'h10,0, 4,1,1,0,0); // single enabled channel, continuous
      tbl[11] = mk(0,0,8'h10,0, 4,1,1,0,0);
      tbl[12] = mk(0,0,8'h10,0, 4,1,1,0,0);
      tbl[13] = mk(0,0,8'h10,0, 4,1,1,1,1);
      tbl[14] = mk(0,0,8'h10,0, 4,1,1,0,0);
      tbl[15] = mk(0,0,8'h10,0, 4,1,1,0,0);
      tbl[16] = mk(0,0,8'h10,0, 4,1,1,0,0);
      tbl[17] = mk(0,0,8'h10,0, 4,1,1,1,1);
      tbl[18] = mk(0,1,8'h10,0, 0,0,0,0,0);
      tbl[19] = mk(1,0,8'h80,1, 7,1,1,0,0); // single pass on channel 7
      tbl[20] = mk(0,0,8'h00,0, 7,1,1,0,0);
      tbl[21] = mk(0,0,8'h00,0, 7,1,1,0,0);
      tbl[22] = mk(0,0,8'h00,0, 7,1,1,1,1);
      tbl[23] = mk(1,0,8'h01,1, 0,0,0,0,0); // last scan cycle: start ignored
      tbl[24] = mk(1,0,8'h01,1, 0,1,1,0,0); // first IDLE cycle: start accepted
      tbl[25] = mk(0,0,8'h00,0, 0,1,1,0,0);
      tbl[26] = mk(0,0,8'h00,0, 0,1,1,0,0);
      tbl[27] = mk(0,0,8'h00,0, 0,1,1,1,1);
      tbl[28] = mk(0,0,8'h00,0, 0,0,0,0,0);

      #1;
      check("reset_state", 0,0,0,0,0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 29; i++) begin
         step(tbl[i].start, tbl[i].stop, tbl[i].mask, tbl[i].single, 1'b0);
         check($sformatf("vec%0d", i), tbl[i].sel, tbl[i].v, tbl[i].b, tbl[i].cd, tbl[i].pd);
      end

      // Continuous scan over mask A4: sel runs 2,5,7,2,5,7 and pass_done comes with channel 7.
      step(1,0,8'hA4,0,0);
      for (k = 0; k < 24; k++) begin
         if (k > 0) step(0,0,8'h00,0,0);
         check($sformatf("cont%0d", k), 3'(seq[(k/4)%3]), 1, 1,
               (k%4) == 3, ((k%4) == 3) && (seq[(k/4)%3] == 7));
      end
      step(0,1,8'h00,0,0);
      check("cont_stop", 0,0,0,0,0);

      // Full single pass over all eight channels.
      step(1,0,8'hFF,1,0);
      for (k = 0; k < 32; k++) begin
         if (k > 0) step(0,0,8'h00,0,0);
         check($sformatf("ff%0d", k), 3'(k/4), 1, 1, (k%4) == 3, k == 31);
      end
      step(0,0,8'h00,0,0);
      check("ff_end", 0,0,0,0,0);

      // Asynchronous reset in the middle of a scan, while sel is 5.
      step(1,0,8'hFF,1,0);
      k = 0;
      while (sel != 3'd5 && k < 40) begin
         step(0,0,8'h00,0,0);
         k++;
      end
      tests++;
      if (sel != 3'd5) begin
         fails++;
         $display("FAIL reach_sel5: got sel=%0d, want 5", sel);
      end
      #2 rst_n = 1'b0;
      #1;
      check("async_reset", 0,0,0,0,0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

`ifdef CHANNEL_SCANNER_HOLD_EN
      // Hold for 3 cycles at count 2: channel 0 stays up for 7 cycles.
      step(1,0,8'h03,1,0);
      check("hold_c0", 0,1,1,0,0);
      step(0,0,8'h00,0,0); check("hold_c1", 0,1,1,0,0);
      step(0,0,8'h00,0,1); check("hold_c2", 0,1,1,0,0);
      step(0,0,8'h00,0,1); check("hold_c3", 0,1,1,0,0);
      step(0,0,8'h00,0,1); check("hold_c4", 0,1,1,0,0);
      step(0,0,8'h00,0,0); check("hold_c5", 0,1,1,0,0);
      step(0,0,8'h00,0,0); check("hold_c6", 0,1,1,1,0);
      for (k = 0; k < 4; k++) begin
         step(0,0,8'h00,0,0);
         check($sformatf("hold_ch1_%0d", k), 1, 1, 1, k == 3, k == 3);
      end
      step(0,0,8'h00,0,0); check("hold_end", 0,0,0,0,0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
